// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// then presents diff, unsigned borrow-out and signed overflow until the next
// accepted start.
module serial_subtractor #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         ready,
   output logic         valid,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         overflow
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_sh_q, a_sh_d;
   logic [N-1:0]   b_sh_q, b_sh_d;
   logic [N-1:0]   res_q, res_d;
   logic           br_q, br_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   diff_q, diff_d;
   logic           bout_q, bout_d;
   logic           ovf_q, ovf_d;

   // Single-bit full-subtractor slice, fed by the LSBs of the shift registers.
   logic bit_d, bit_br;
   assign bit_d  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
   assign bit_br = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = {1'b0, a_sh_q[N-1:1]};
            b_sh_d = {1'b0, b_sh_q[N-1:1]};
            res_d  = {bit_d, res_q[N-1:1]};
            br_d   = bit_br;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               // Last bit: br_q is the borrow into the sign bit, bit_br the borrow out.
               cnt_d   = cnt_q;
               diff_d  = {bit_d, res_q[N-1:1]};
               bout_d  = bit_br;
               ovf_d   = br_q ^ bit_br;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst low.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready    = (state_q != RUN);
   assign valid    = (state_q == DONE);
   assign diff     = diff_q;
   assign bout     = bout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N = 8).
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         ready;
   logic         valid;
   logic [N-1:0] diff;
   logic         bout;
   logic         overflow;

   int checks;
   int errors;

   serial_subtractor #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .ready    (ready),
      .valid    (valid),
      .diff     (diff),
      .bout     (bout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait for the next rising edge and step 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
      end
   endtask

   // Accept an operation, scramble the operand inputs, and check valid rises
   // exactly N edges after the accept edge with the expected result.
   task automatic run_op(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic bi, input logic [N-1:0] exp_diff,
                         input logic exp_bout, input logic exp_ovf);
      start = 1'b1; a = av; b = bv; bin = bi;
      tick();
      start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
      chk_bit({name, " ready_in_run"}, ready, 1'b0);
      chk_bit({name, " valid_in_run"}, valid, 1'b0);
      repeat (N - 2) tick();
      tick();
      chk_bit({name, " valid_early"}, valid, 1'b0);
      tick();
      chk_bit({name, " valid"}, valid, 1'b1);
      chk_bit({name, " ready"}, ready, 1'b1);
      chk_vec({name, " diff"}, diff, exp_diff);
      chk_bit({name, " bout"}, bout, exp_bout);
      chk_bit({name, " overflow"}, overflow, exp_ovf);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk_bit("reset ready", ready, 1'b1);
      chk_bit("reset valid", valid, 1'b0);
      chk_vec("reset diff", diff, 8'h00);
      chk_bit("reset bout", bout, 1'b0);
      chk_bit("reset overflow", overflow, 1'b0);
      tick();
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_basic();
      run_op("100-37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
      run_op("0-1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      run_op("80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
   endtask

   task automatic test_borrow_in();
      run_op("5-5-1", 8'd5, 8'd5, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op("5-4-1", 8'd5, 8'd4, 1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   // start pulsed with new operands during RUN must be ignored.
   task automatic test_start_in_run();
      start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
      tick();
      start = 1'b0; a = '0; b = '0;
      repeat (2) tick();
      start = 1'b1; a = 8'd1; b = 8'd200; bin = 1'b1;
      tick();
      start = 1'b0;
      chk_bit("run_start ready", ready, 1'b0);
      repeat (N - 4) tick();
      chk_bit("run_start valid_early", valid, 1'b0);
      tick();
      chk_bit("run_start valid", valid, 1'b1);
      chk_vec("run_start diff", diff, 8'd30);
      chk_bit("run_start bout", bout, 1'b0);
      chk_bit("run_start overflow", overflow, 1'b0);
   endtask

   // rst low mid-RUN aborts; no valid afterwards; next start accepted at once.
   task automatic test_reset_mid_run();
      int seen_valid;
      start = 1'b1; a = 8'd9; b = 8'd3; bin = 1'b0;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      chk_bit("abort ready", ready, 1'b1);
      chk_bit("abort valid", valid, 1'b0);
      chk_vec("abort diff", diff, 8'h00);
      chk_bit("abort bout", bout, 1'b0);
      chk_bit("abort overflow", overflow, 1'b0);
      tick();
      @(negedge clk);
      rst = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 2 * N; i++) begin
         tick();
         if (valid) seen_valid++;
      end
      checks++;
      if (seen_valid != 0) begin
         errors++;
         $display("FAIL abort no_valid: valid seen %0d cycles expected 0", seen_valid);
      end
      run_op("200-55", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0);
   endtask

   // Accept from DONE: valid falls that edge, old result held until completion.
   task automatic test_back_to_back();
      run_op("b2b first", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);
      start = 1'b1; a = 8'd3; b = 8'd10; bin = 1'b0;
      tick();
      start = 1'b0;
      chk_bit("b2b valid_fall", valid, 1'b0);
      chk_vec("b2b diff_hold", diff, 8'd7);
      repeat (N / 2) tick();
      chk_vec("b2b diff_hold_mid", diff, 8'd7);
      repeat (N - 1 - N / 2) tick();
      chk_bit("b2b valid_early", valid, 1'b0);
      tick();
      chk_bit("b2b valid", valid, 1'b1);
      chk_vec("b2b diff", diff, 8'hF9);
      chk_bit("b2b bout", bout, 1'b1);
      chk_bit("b2b overflow", overflow, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_borrow_in();
      test_start_in_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
